// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: one-hot FSM state
// encodings and a width helper for counters and source indices.
package uart_tx_arbiter_pkg;

  localparam logic [3:0] ST_IDLE       = 4'b0001;
  localparam logic [3:0] ST_SEND       = 4'b0010;
  localparam logic [3:0] ST_WAIT_START = 4'b0100;
  localparam logic [3:0] ST_WAIT_DONE  = 4'b1000;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_rr_pick: combinational round-robin priority picker. Returns the first
// requester at or above ptr_i, wrapping at N-1, so N need not be a power of two.
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int unsigned N = 2,
  localparam int unsigned W = width_for(N - 1)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_vld_o
);

  int idx;

  // Scan from the farthest position back toward ptr_i so the nearest requester wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= int'(N)) idx = idx - int'(N);
      if (req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_SRC packet sources.
// A whole packet is granted at a time, round-robin, and streamed byte by byte
// through the UART transmit / is_transmitting handshake.
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a packet whose source
// stalls for TIMEOUT_CYCLES in SEND (sets sticky timeout_err).
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned MAX_PKT_LEN    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                                  sys_clk,
  input  logic                                  rst_n,
  input  logic [NUM_SRC-1:0]                    src_valid,
  input  logic [8*NUM_SRC-1:0]                  src_data,
  input  logic [NUM_SRC-1:0]                    src_last,
  output logic [NUM_SRC-1:0]                    src_ready,
  output logic                                  uart_transmit,
  output logic [7:0]                            uart_tx_byte,
  input  logic                                  uart_is_transmitting,
  output logic [width_for(NUM_SRC-1)-1:0]       grant_id,
  output logic                                  busy,
  output logic                                  pkt_done,
  output logic                                  len_err,
  output logic                                  timeout_err
);

  localparam int unsigned GW = width_for(NUM_SRC - 1);
  localparam int unsigned CW = width_for(MAX_PKT_LEN);

  if (NUM_SRC < 2 || MAX_PKT_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_SRC>=2, MAX_PKT_LEN>=1, TIMEOUT_CYCLES>=2 required");
  end

  logic [3:0]    state_q,   state_d;
  logic [GW-1:0] grant_q,   grant_d;
  logic [GW-1:0] rr_q,      rr_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          last_q,    last_d;
  logic          tx_q,      tx_d;
  logic [7:0]    byte_q,    byte_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          len_err_q, len_err_d;

  logic          sel_valid, sel_last;
  logic [7:0]    sel_data;
  logic          send_open, hs, at_limit;
  logic [GW-1:0] pick_idx;
  logic          pick_vld;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = width_for(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_err_q, to_err_d;
`endif

  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] p);
    return (p == GW'(NUM_SRC - 1)) ? '0 : p + GW'(1);
  endfunction

  uart_rr_pick #(.N(NUM_SRC)) u_pick (
    .req_i     (src_valid),
    .ptr_i     (rr_q),
    .gnt_idx_o (pick_idx),
    .gnt_vld_o (pick_vld)
  );

  // Route the granted source's valid/last/data onto a single lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[8*i +: 8];
      end
    end
  end

  assign send_open = (state_q == ST_SEND) && !uart_is_transmitting;
  assign hs        = send_open && sel_valid;
  assign at_limit  = (cnt_q == CW'(MAX_PKT_LEN - 1));

  // Only the granted source sees ready, and only while the UART can take a byte.
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_ready[i] = send_open && (grant_q == GW'(i));
    end
  end

  // Packet-level FSM: grant in IDLE, one byte per SEND, then follow the UART busy flag.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    tx_d      = 1'b0;
    byte_d    = byte_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    len_err_d = len_err_q;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    to_err_d  = to_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SEND;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      ST_SEND: begin
        if (hs) begin
          byte_d  = sel_data;
          tx_d    = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          last_d  = sel_last | at_limit;
          if (at_limit && !sel_last) len_err_d = 1'b1;
          state_d = ST_WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_d = '0;
        end else if (!sel_valid) begin
          if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            to_err_d = 1'b1;
            to_cnt_d = '0;
            busy_d   = 1'b0;
            rr_d     = rr_next(grant_q);
            state_d  = ST_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
`endif
        end
      end
      ST_WAIT_START: begin
        if (uart_is_transmitting) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          if (last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rr_d    = rr_next(grant_q);
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset returns every output to zero.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      tx_q      <= 1'b0;
      byte_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      tx_q      <= tx_d;
      byte_q    <= byte_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Stall counter and sticky abort flag.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign uart_transmit = tx_q;
  assign uart_tx_byte  = byte_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign pkt_done      = done_q;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven sources, a UART busy model and a
// packet-level reference that predicts the byte stream on the wire.
module tb_uart_tx_arbiter;

  localparam int NSRC = 3;
  localparam int MAXL = 64;
  localparam int TOC  = 64;
  localparam logic [15:0] MARK = 16'h8000;

  typedef struct {
    logic [7:0] b;
    logic       last;
    int         gap;
  } ent_t;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic [NSRC-1:0]   src_valid;
  logic [8*NSRC-1:0] src_data;
  logic [NSRC-1:0]   src_last;
  logic [NSRC-1:0]   src_ready;
  logic              uart_transmit;
  logic [7:0]        uart_tx_byte;
  logic              uart_is_transmitting;
  logic [1:0]        grant_id;
  logic              busy, pkt_done, len_err, timeout_err;

  ent_t        srcq[NSRC][$];
  logic [15:0] obs[$];
  logic [15:0] expq[$];
  int          pops[NSRC];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          uart_dur = 3;
  int          rr_m     = 0;
  logic        len_err_m = 1'b0;
  logic        to_err_m  = 1'b0;

  uart_tx_arbiter #(.NUM_SRC(NSRC), .MAX_PKT_LEN(MAXL), .TIMEOUT_CYCLES(TOC)) dut (
    .sys_clk              (sys_clk),
    .rst_n                (rst_n),
    .src_valid            (src_valid),
    .src_data             (src_data),
    .src_last             (src_last),
    .src_ready            (src_ready),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .grant_id             (grant_id),
    .busy                 (busy),
    .pkt_done             (pkt_done),
    .len_err              (len_err),
    .timeout_err          (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Source driver: present queue heads, honour per-byte gaps, pop on handshake.
  initial begin
    logic [NSRC-1:0] hs;
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    forever begin
      @(negedge sys_clk);
      hs = src_valid & src_ready;
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < NSRC; i++) begin
        if (hs[i] && srcq[i].size() > 0) begin
          void'(srcq[i].pop_front());
          pops[i]++;
        end
        src_valid[i] = 1'b0;
        src_last[i]  = 1'b0;
        src_data[8*i +: 8] = 8'h00;
        if (srcq[i].size() > 0) begin
          if (srcq[i][0].gap > 0) begin
            srcq[i][0].gap = srcq[i][0].gap - 1;
          end else begin
            src_valid[i] = 1'b1;
            src_last[i]  = srcq[i][0].last;
            src_data[8*i +: 8] = srcq[i][0].b;
          end
        end
      end
    end
  end

  // UART model: busy starts the cycle after a transmit pulse and lasts uart_dur cycles.
  initial begin
    uart_is_transmitting = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (uart_transmit === 1'b1) begin
        @(posedge sys_clk);
        #1 uart_is_transmitting = 1'b1;
        repeat (uart_dur) @(posedge sys_clk);
        #1 uart_is_transmitting = 1'b0;
      end
    end
  end

  // Monitor: protocol checks each cycle and capture of the wire stream.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst_n === 1'b1) begin
        check("ready_onehot0", $onehot0(src_ready), 1);
        if (src_ready != '0) check("ready_owner", src_ready, 64'(1) << grant_id);
        if (uart_transmit) begin
          check("tx_while_uart_busy", uart_is_transmitting, 0);
          obs.push_back({1'b0, 7'(grant_id), uart_tx_byte});
        end
        if (pkt_done) begin
          check("done_with_busy", busy, 0);
          obs.push_back(MARK);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input int s, input logic [7:0] b, input logic last, input int gap);
    ent_t e;
    e.b = b; e.last = last; e.gap = gap;
    srcq[s].push_back(e);
  endtask

  task automatic push_rand_pkt(input int s, input int len, input int max_gap);
    for (int k = 0; k < len; k++)
      push_byte(s, 8'($urandom), (k == len - 1), (k == 0) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NSRC; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: whole packets, round-robin from rr_m, each cut at MAXL bytes.
  task automatic build_expected();
    ent_t mq[NSRC][$];
    ent_t e;
    int   s, c, cnt;
    bit   done;
    for (int i = 0; i < NSRC; i++) mq[i] = srcq[i];
    forever begin
      s = -1;
      for (int k = 0; k < NSRC; k++) begin
        c = (rr_m + k) % NSRC;
        if (s < 0 && mq[c].size() > 0) s = c;
      end
      if (s < 0) break;
      cnt = 0;
      done = 1'b0;
      while (!done && mq[s].size() > 0) begin
        e = mq[s].pop_front();
        cnt++;
        expq.push_back({1'b0, 7'(s), e.b});
        if (!e.last && cnt == MAXL) len_err_m = 1'b1;
        done = e.last || (cnt == MAXL);
      end
      expq.push_back(MARK);
      rr_m = (s + 1) % NSRC;
    end
  endtask

  task automatic run_and_check(input string name, input int budget);
    int t = 0;
    int n;
    @(negedge sys_clk);
    while (t < budget && !(all_empty() && !busy && !uart_is_transmitting)) begin
      @(negedge sys_clk);
      t++;
    end
    check({name, "_drain_in_budget"}, (t < budget), 1);
    repeat (3) @(negedge sys_clk);
    check({name, "_stream_len"}, obs.size(), expq.size());
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int k = 0; k < n; k++)
      check($sformatf("%s_stream[%0d]", name, k), obs[k], expq[k]);
    check({name, "_len_err"}, len_err, len_err_m);
    check({name, "_timeout_err"}, timeout_err, to_err_m);
    obs.delete();
    expq.delete();
  endtask

  task automatic apply_reset();
    @(posedge sys_clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    rr_m = 0; len_err_m = 1'b0; to_err_m = 1'b0;
  endtask

  task automatic start_scenario();
    @(posedge sys_clk);
    #2;
    for (int i = 0; i < NSRC; i++) pops[i] = 0;
  endtask

  initial begin
    int t;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_transmit", uart_transmit, 0);
    check("rst_tx_byte", uart_tx_byte, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_ready", src_ready, 0);
    @(posedge sys_clk);
    #1 rst_n = 1'b1;

    // Single 3-byte packet through a slow UART.
    uart_dur = 160;
    start_scenario();
    push_byte(0, 8'h08, 1'b0, 0);
    push_byte(0, 8'h00, 1'b0, 0);
    push_byte(0, 8'h00, 1'b1, 0);
    build_expected();
    run_and_check("t1", 2000);

    // Two sources together straight out of reset.
    apply_reset();
    uart_dur = 2;
    start_scenario();
    push_rand_pkt(0, 4, 0);
    push_rand_pkt(1, 3, 0);
    build_expected();
    run_and_check("t2", 500);

    // Back-to-back packets from src0 while src1 waits.
    start_scenario();
    push_rand_pkt(0, 3, 1);
    push_rand_pkt(0, 2, 1);
    push_rand_pkt(1, 4, 1);
    build_expected();
    run_and_check("t3", 800);

    // Oversized packet gets cut at MAXL; the tail is its own grant.
    uart_dur = 1;
    start_scenario();
    push_rand_pkt(0, 70, 0);
    build_expected();
    run_and_check("t4", 3000);

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      uart_dur = $urandom_range(1, 5);
      start_scenario();
      for (int s = 0; s < NSRC; s++) begin
        int np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) push_rand_pkt(s, $urandom_range(1, 6), 3);
      end
      if (all_empty()) push_rand_pkt($urandom_range(0, NSRC - 1), 2, 3);
      build_expected();
      run_and_check($sformatf("rnd%0d", r), 2000);
    end

    // Source stall mid-packet.
    uart_dur = 3;
    start_scenario();
    push_byte(0, 8'hA1, 1'b0, 0);
    push_byte(0, 8'hA2, 1'b0, 0);
    push_byte(0, 8'hA3, 1'b0, 200);
    push_byte(0, 8'hA4, 1'b1, 0);
    build_expected();
    t = 0;
    while (pops[0] < 2 && t < 500) begin @(negedge sys_clk); t++; end
    check("t5_reach_stall", (t < 500), 1);
    repeat (120) @(negedge sys_clk);
`ifdef UART_ARB_TIMEOUT_EN
    check("t5_busy", busy, 0);
    check("t5_timeout_err", timeout_err, 1);
    check("t5_ready", src_ready, 0);
    to_err_m = 1'b1;
`else
    check("t5_busy", busy, 1);
    check("t5_grant", grant_id, 0);
    check("t5_timeout_err", timeout_err, 0);
    check("t5_ready", src_ready, 3'b001);
`endif
    run_and_check("t5", 1000);

    // Reset while the UART is mid-byte.
    uart_dur = 20;
    start_scenario();
    push_rand_pkt(1, 3, 0);
    t = 0;
    while (pops[1] < 1 && t < 200) begin @(negedge sys_clk); t++; end
    check("t6_reach_byte", (t < 200), 1);
    repeat (8) @(posedge sys_clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_grant", grant_id, 0);
    check("t6_transmit", uart_transmit, 0);
    check("t6_tx_byte", uart_tx_byte, 0);
    check("t6_pkt_done", pkt_done, 0);
    check("t6_len_err", len_err, 0);
    check("t6_timeout_err", timeout_err, 0);
    check("t6_ready", src_ready, 0);
    for (int i = 0; i < NSRC; i++) srcq[i].delete();
    rr_m = 0; len_err_m = 1'b0; to_err_m = 1'b0;
    t = 0;
    while (uart_is_transmitting && t < 200) begin @(negedge sys_clk); t++; end
    check("t6_uart_finishes", (t < 200), 1);
    repeat (2) @(posedge sys_clk);
    obs.delete();
    expq.delete();
    #1 rst_n = 1'b1;
    uart_dur = 2;
    start_scenario();
    push_rand_pkt(2, 2, 0);
    push_rand_pkt(0, 3, 0);
    build_expected();
    run_and_check("t6", 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
